// File: rtl/pico_link_pkg.sv
// pico_link_pkg
//   Shared definitions for the Pico -> iCE40 receive link:
//   - state_t  : receive FSM states
//   - *_RST    : reset values of the three pin synchronisers (idle line levels)
package pico_link_pkg;

  typedef enum logic [1:0] {
    ST_RESYNC = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  // Idle levels of the serial lines: clock low, data low, frame deselected.
  localparam logic SCLK_RST  = 1'b0;
  localparam logic SDATA_RST = 1'b0;
  localparam logic CS_N_RST  = 1'b1;

endpackage

// File: rtl/pico_in_sync.sv
// pico_in_sync
//   Multi-flop synchroniser for one asynchronous input pin.
//   Ports:
//     clock    in  system clock
//     resetn   in  synchronous active-low reset
//     i_async  in  asynchronous pin
//     o_sync   out synchronised pin (STAGES clocks of latency)
//   Parameters:
//     STAGES   number of flops in the chain (>= 2)
//     RST_VAL  value loaded into every flop on reset
module pico_in_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic resetn,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] r_chain;

  // NOTE: non-blocking assignments let every flop sample its neighbour's old
  // value, so the chain shifts by exactly one stage per clock.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_chain <= {STAGES{RST_VAL}};
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_chain[STAGES-1];

endmodule

// File: rtl/pico_link_rx.sv
// pico_link_rx
//   Receives bit-banged frames from the RP2040 (sclk / sdata / cs_n) and
//   presents each completed word on a valid/ready port.
//   Ports:
//     clock, resetn        system clock, synchronous active-low reset
//     pico_sclk/sdata/cs_n asynchronous serial lines from the Pico
//     rx_data, rx_first    received word and first-word-of-frame qualifier
//     rx_valid, rx_ready   output handshake
//     frame_active         FSM is inside a frame
//     overrun, frame_err   sticky error flags, cleared by err_clr
module pico_link_rx
  import pico_link_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              pico_sclk,
  input  logic              pico_sdata,
  input  logic              pico_cs_n,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_first,
  output logic              frame_active,
  output logic              overrun,
  output logic              frame_err,
  input  logic              err_clr
);

  localparam int CNT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int FLUSH_W = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]   LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_CNT = FLUSH_W'(SYNC_STAGES);

  logic w_sclk, w_sdata, w_cs_n;

  pico_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(SCLK_RST)) u_sync_sclk (
    .clock(clock), .resetn(resetn), .i_async(pico_sclk), .o_sync(w_sclk)
  );
  pico_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(SDATA_RST)) u_sync_sdata (
    .clock(clock), .resetn(resetn), .i_async(pico_sdata), .o_sync(w_sdata)
  );
  pico_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CS_N_RST)) u_sync_cs_n (
    .clock(clock), .resetn(resetn), .i_async(pico_cs_n), .o_sync(w_cs_n)
  );

  state_t              r_state;
  logic                r_sclk_prev;
  logic [FLUSH_W-1:0]  r_flush_cnt;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [DATA_W-1:0]   r_shift;
  logic                r_first_flag;
  logic [DATA_W-1:0]   r_rx_data;
  logic                r_rx_valid;
  logic                r_rx_first;
  logic                r_overrun;
  logic                r_frame_err;

  logic                w_sclk_edge;
  logic                w_sample;
  logic                w_complete;
  logic                w_handshake;
  logic                w_frame_end;
  logic                w_overrun_set;
  logic                w_frame_err_set;
  logic [DATA_W-1:0]   w_word;

  assign w_sclk_edge = w_sclk & ~r_sclk_prev;

  // A rising cs_n ends the frame even if an edge lands in the same cycle.
  assign w_sample        = (r_state == ST_ACTIVE) && !w_cs_n && w_sclk_edge;
  assign w_complete      = w_sample && (r_bit_cnt == LAST_BIT);
  assign w_handshake     = r_rx_valid && rx_ready;
  assign w_frame_end     = (r_state == ST_ACTIVE) && w_cs_n;
  assign w_overrun_set   = w_complete && r_rx_valid && !rx_ready;
  assign w_frame_err_set = w_frame_end && (r_bit_cnt != '0);

  // Shift register contents after the current sample, including the new bit.
  // NOTE: always_comb assigns w_word on every path, so no latch is inferred.
  always_comb begin
    w_word = r_shift;
    if (MSB_FIRST) begin
      w_word = {r_shift[DATA_W-2:0], w_sdata};
    end else begin
      w_word = {w_sdata, r_shift[DATA_W-1:1]};
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state      <= ST_RESYNC;
      r_sclk_prev  <= SCLK_RST;
      r_flush_cnt  <= FLUSH_CNT;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_first_flag <= 1'b0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_first   <= 1'b0;
      r_overrun    <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_sclk_prev <= w_sclk;

      // The synchronisers hold their reset value for SYNC_STAGES clocks after
      // release; wait for the real pin level before trusting cs_n, otherwise
      // a frame in progress at reset would be mistaken for an idle line.
      if (r_flush_cnt != '0) begin
        r_flush_cnt <= r_flush_cnt - FLUSH_W'(1);
      end

      case (r_state)
        ST_RESYNC: begin
          if ((r_flush_cnt == '0) && w_cs_n) begin
            r_state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (!w_cs_n) begin
            r_state      <= ST_ACTIVE;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_first_flag <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (w_cs_n) begin
            r_state <= ST_IDLE;
          end else if (w_sclk_edge) begin
            r_shift   <= w_word;
            r_bit_cnt <= w_complete ? '0 : r_bit_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_RESYNC;
      endcase

      // Output register: a completion may reload it in the very cycle the
      // consumer takes the held word.
      if (w_complete && (!r_rx_valid || w_handshake)) begin
        r_rx_data    <= w_word;
        r_rx_first   <= r_first_flag;
        r_rx_valid   <= 1'b1;
        r_first_flag <= 1'b0;
      end else if (w_handshake) begin
        r_rx_valid <= 1'b0;
      end

      // Sticky flags: a fresh error beats a simultaneous clear.
      r_overrun   <= w_overrun_set   | (r_overrun   & ~err_clr);
      r_frame_err <= w_frame_err_set | (r_frame_err & ~err_clr);
    end
  end

  assign rx_data      = r_rx_data;
  assign rx_valid     = r_rx_valid;
  assign rx_first     = r_rx_first;
  assign frame_active = (r_state == ST_ACTIVE);
  assign overrun      = r_overrun;
  assign frame_err    = r_frame_err;

endmodule

// File: tb/tb_pico_link_rx.sv
// tb_pico_link_rx
//   Directed bench for pico_link_rx. Two instances share the serial pins:
//   u_msb (MSB_FIRST=1) and u_lsb (MSB_FIRST=0), so each frame checks both
//   bit orders. Accepted words are captured into queues on the falling edge.
module tb_pico_link_rx;

  localparam int HALF = 4; // clocks per sclk phase (>= SYNC_STAGES+1)

  logic       clock = 1'b0;
  logic       resetn;
  logic       pico_sclk, pico_sdata, pico_cs_n;
  logic       rx_ready, err_clr;

  logic [7:0] rx_data_m, rx_data_l;
  logic       rx_valid_m, rx_valid_l;
  logic       rx_first_m, rx_first_l;
  logic       frame_active_m, frame_active_l;
  logic       overrun_m, overrun_l;
  logic       frame_err_m, frame_err_l;

  int checks   = 0;
  int failures = 0;

  logic [8:0] q_m[$]; // {rx_first, rx_data} per accepted word
  logic [8:0] q_l[$];

  always #5 clock = ~clock;

  pico_link_rx #(.DATA_W(8), .SYNC_STAGES(2), .MSB_FIRST(1'b1)) u_msb (
    .clock(clock), .resetn(resetn),
    .pico_sclk(pico_sclk), .pico_sdata(pico_sdata), .pico_cs_n(pico_cs_n),
    .rx_data(rx_data_m), .rx_valid(rx_valid_m), .rx_ready(rx_ready),
    .rx_first(rx_first_m), .frame_active(frame_active_m),
    .overrun(overrun_m), .frame_err(frame_err_m), .err_clr(err_clr)
  );

  pico_link_rx #(.DATA_W(8), .SYNC_STAGES(2), .MSB_FIRST(1'b0)) u_lsb (
    .clock(clock), .resetn(resetn),
    .pico_sclk(pico_sclk), .pico_sdata(pico_sdata), .pico_cs_n(pico_cs_n),
    .rx_data(rx_data_l), .rx_valid(rx_valid_l), .rx_ready(rx_ready),
    .rx_first(rx_first_l), .frame_active(frame_active_l),
    .overrun(overrun_l), .frame_err(frame_err_l), .err_clr(err_clr)
  );

  always @(negedge clock) begin
    if (resetn && rx_valid_m && rx_ready) q_m.push_back({rx_first_m, rx_data_m});
    if (resetn && rx_valid_l && rx_ready) q_l.push_back({rx_first_l, rx_data_l});
  end

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit pulse_ready);
    pico_sdata = b;
    pico_sclk  = 1'b0;
    tick(HALF);
    pico_sclk  = 1'b1;
    if (pulse_ready) begin
      // Ready is high only across the edge that completes the word.
      tick(2);
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      tick(HALF - 3);
    end else begin
      tick(HALF);
    end
    pico_sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, input bit pulse_last);
    for (int i = 7; i >= 0; i--) send_bit(v[i], pulse_last && (i == 0));
  endtask

  task automatic frame_open();
    pico_cs_n = 1'b0;
    tick(HALF);
  endtask

  task automatic frame_close();
    tick(HALF);
    pico_cs_n = 1'b1;
    tick(HALF + 2);
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] exp_msb;
    logic [7:0] exp_lsb;
  } vec_t;

  vec_t vecs[5];

  initial begin
    // Second field: word seen MSB-first; third: bit-reversed (LSB-first).
    vecs[0] = '{8'hA5, 8'hA5, 8'hA5};
    vecs[1] = '{8'h80, 8'h80, 8'h01};
    vecs[2] = '{8'h12, 8'h12, 8'h48};
    vecs[3] = '{8'hF0, 8'hF0, 8'h0F};
    vecs[4] = '{8'hC1, 8'hC1, 8'h83};

    resetn     = 1'b0;
    pico_sclk  = 1'b0;
    pico_sdata = 1'b0;
    pico_cs_n  = 1'b1;
    rx_ready   = 1'b1;
    err_clr    = 1'b0;
    tick(4);

    // Reset state
    check("rst_rx_data",      32'(rx_data_m),      32'h00);
    check("rst_rx_valid",     32'(rx_valid_m),     32'h0);
    check("rst_rx_first",     32'(rx_first_m),     32'h0);
    check("rst_frame_active", 32'(frame_active_m), 32'h0);
    check("rst_overrun",      32'(overrun_m),      32'h0);
    check("rst_frame_err",    32'(frame_err_m),    32'h0);
    resetn = 1'b1;
    tick(8);

    // Single-word frames, ready held high
    for (int v = 0; v < 5; v++) begin
      q_m.delete();
      q_l.delete();
      frame_open();
      send_byte(vecs[v].tx, 1'b0);
      frame_close();
      check($sformatf("vec%0d_count", v), 32'(q_m.size()), 32'd1);
      if (q_m.size() == 1) begin
        check($sformatf("vec%0d_msb_word", v), 32'(q_m[0]), {23'd0, 1'b1, vecs[v].exp_msb});
      end
      check($sformatf("vec%0d_lsb_count", v), 32'(q_l.size()), 32'd1);
      if (q_l.size() == 1) begin
        check($sformatf("vec%0d_lsb_word", v), 32'(q_l[0]), {23'd0, 1'b1, vecs[v].exp_lsb});
      end
      check($sformatf("vec%0d_errs", v), {30'd0, overrun_m, frame_err_m}, 32'd0);
      check($sformatf("vec%0d_valid_low", v), 32'(rx_valid_m), 32'd0);
    end

    // Three words in one frame; first flag only on the first
    q_m.delete();
    q_l.delete();
    frame_open();
    check("multi_frame_active_hi", 32'(frame_active_m), 32'd1);
    send_byte(8'h3C, 1'b0);
    send_byte(8'hC3, 1'b0);
    send_byte(8'hFF, 1'b0);
    frame_close();
    check("multi_frame_active_lo", 32'(frame_active_m), 32'd0);
    check("multi_count", 32'(q_m.size()), 32'd3);
    if (q_m.size() == 3) begin
      check("multi_w0", 32'(q_m[0]), 32'h13C);
      check("multi_w1", 32'(q_m[1]), 32'h0C3);
      check("multi_w2", 32'(q_m[2]), 32'h0FF);
    end

    // Overrun: consumer stalled for two words
    q_m.delete();
    q_l.delete();
    rx_ready = 1'b0;
    frame_open();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    frame_close();
    check("ovr_valid",   32'(rx_valid_m), 32'd1);
    check("ovr_data",    32'(rx_data_m),  32'h11);
    check("ovr_first",   32'(rx_first_m), 32'd1);
    check("ovr_flag",    32'(overrun_m),  32'd1);
    check("ovr_no_hs",   32'(q_m.size()), 32'd0);
    rx_ready = 1'b1;
    tick(1);
    check("ovr_accept_valid", 32'(rx_valid_m), 32'd0);
    check("ovr_accept_count", 32'(q_m.size()), 32'd1);
    if (q_m.size() == 1) check("ovr_accept_word", 32'(q_m[0]), 32'h111);
    check("ovr_still_set", 32'(overrun_m), 32'd1);
    pulse_err_clr();
    check("ovr_cleared", 32'(overrun_m), 32'd0);

    // Frame ends after 5 bits
    q_m.delete();
    q_l.delete();
    frame_open();
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    frame_close();
    check("ferr_flag",   32'(frame_err_m), 32'd1);
    check("ferr_no_word", 32'(q_m.size()),  32'd0);
    check("ferr_valid",  32'(rx_valid_m),  32'd0);
    frame_open();
    send_byte(8'h5A, 1'b0);
    frame_close();
    check("ferr_next_count", 32'(q_m.size()), 32'd1);
    if (q_m.size() == 1) check("ferr_next_word", 32'(q_m[0]), 32'h15A);
    pulse_err_clr();
    check("ferr_cleared", 32'(frame_err_m), 32'd0);

    // Reset mid-frame: the frame in progress must not be decoded
    q_m.delete();
    q_l.delete();
    frame_open();
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    resetn = 1'b0;
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    resetn = 1'b1;
    send_byte(8'hFF, 1'b0);
    tick(HALF);
    check("rstmid_frame_active", 32'(frame_active_m), 32'd0);
    check("rstmid_no_word",      32'(q_m.size()),     32'd0);
    check("rstmid_valid",        32'(rx_valid_m),     32'd0);
    pico_cs_n = 1'b1;
    tick(HALF + 4);
    frame_open();
    send_byte(8'h81, 1'b0);
    frame_close();
    check("rstmid_next_count", 32'(q_m.size()), 32'd1);
    if (q_m.size() == 1) check("rstmid_next_word", 32'(q_m[0]), 32'h181);

    // Word completes in the same cycle the held word is accepted
    q_m.delete();
    q_l.delete();
    rx_ready = 1'b0;
    frame_open();
    send_byte(8'h33, 1'b0);
    check("ovl_held", 32'(rx_data_m), 32'h33);
    send_byte(8'h44, 1'b1);
    frame_close();
    check("ovl_count",   32'(q_m.size()), 32'd1);
    if (q_m.size() == 1) check("ovl_first_word", 32'(q_m[0]), 32'h133);
    check("ovl_valid",   32'(rx_valid_m), 32'd1);
    check("ovl_data",    32'(rx_data_m),  32'h44);
    check("ovl_first",   32'(rx_first_m), 32'd0);
    check("ovl_overrun", 32'(overrun_m),  32'd0);
    rx_ready = 1'b1;
    tick(2);
    check("ovl_count2", 32'(q_m.size()), 32'd2);
    if (q_m.size() == 2) check("ovl_second_word", 32'(q_m[1]), 32'h044);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
